// File: rtl/izh_population_sequencer.sv
// Per-tick sweep controller for the time-multiplexed Izhikevich core: fetches each
// neuron's current, strobes the core through read/write, and collects fire bits.
module izh_population_sequencer #(
    parameter int N_NEURONS = 128,
    parameter int ADDR_W    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 clear_overrun,
    output logic                 cur_req,
    output logic [ADDR_W-1:0]    cur_addr,
    input  logic                 cur_valid,
    input  logic [31:0]          cur_data,
    output logic [ADDR_W-1:0]    core_addr,
    output logic [31:0]          core_I,
    output logic                 core_we,
    output logic                 core_first_pass,
    input  logic                 core_fired,
    output logic                 busy,
    output logic                 sweep_done,
    output logic [N_NEURONS-1:0] population,
    output logic [31:0]          sweep_count,
    output logic                 overrun
);

    typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_t;

    state_t                 state, state_nx;
    logic [ADDR_W-1:0]      idx;
    // The last neuron's bit goes straight into population, so it needs no shadow slot.
    logic [N_NEURONS-2:0]   shadow;
    logic                   last;
    logic                   start;

    assign last      = (idx == ADDR_W'(N_NEURONS - 1));
    assign start     = tick && enable;
    assign cur_addr  = idx;
    assign core_addr = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cur_req    = 1'b0;
        core_we    = 1'b0;
        busy       = 1'b1;
        sweep_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                cur_req = 1'b1;
                if (cur_valid) state_nx = READ;
            end
            READ:  state_nx = WRITE;
            WRITE: begin
                core_we  = 1'b1;
                state_nx = last ? DONE : FETCH;
            end
            DONE: begin
                sweep_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx             <= '0;
            core_I          <= '0;
            shadow          <= '0;
            population      <= '0;
            sweep_count     <= '0;
            core_first_pass <= 1'b1;
        end else begin
            case (state)
                IDLE:  if (start) idx <= '0;
                FETCH: if (cur_valid) core_I <= cur_data;
                WRITE: begin
                    if (last) begin
                        population      <= {core_fired, shadow};
                        sweep_count     <= sweep_count + 32'd1;
                        core_first_pass <= 1'b0;
                    end else begin
                        shadow[idx] <= core_fired;
                        idx         <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A dropped tick outranks a simultaneous clear so no overrun is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                overrun <= 1'b0;
        else if (tick && busy)    overrun <= 1'b1;
        else if (clear_overrun)   overrun <= 1'b0;
    end

endmodule

// File: tb/tb_izh_population_sequencer.sv
// Randomized bench for izh_population_sequencer; expected timing comes from a
// per-neuron schedule (fetch start + wait + read + write) computed arithmetically.
module tb_izh_population_sequencer;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int RW = 6 + 2*AW + 32 + N + 32;

    logic          clk = 1'b0;
    logic          reset, tick, enable, clear_overrun, cur_valid, core_fired;
    logic [31:0]   cur_data;
    logic          cur_req, core_we, core_first_pass, busy, sweep_done, overrun;
    logic [AW-1:0] cur_addr, core_addr;
    logic [31:0]   core_I, sweep_count;
    logic [N-1:0]  population;

    int            n_cmp = 0;
    int            n_bad = 0;

    // reference model state
    logic [N-1:0]  exp_pop;
    logic [31:0]   exp_cnt;
    logic          exp_fp, exp_ovr;
    int            w[N];
    logic [31:0]   d[N];
    logic          f[N];
    logic [RW-1:0] rst_exp;

    izh_population_sequencer #(.N_NEURONS(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable),
        .clear_overrun(clear_overrun), .cur_req(cur_req), .cur_addr(cur_addr),
        .cur_valid(cur_valid), .cur_data(cur_data), .core_addr(core_addr),
        .core_I(core_I), .core_we(core_we), .core_first_pass(core_first_pass),
        .core_fired(core_fired), .busy(busy), .sweep_done(sweep_done),
        .population(population), .sweep_count(sweep_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] outs();
        return {cur_req, core_we, busy, sweep_done, overrun, core_first_pass,
                cur_addr, core_addr, core_I, population, sweep_count};
    endfunction

    task automatic randomize_sweep(input int max_wait);
        for (int j = 0; j < N; j++) begin
            w[j] = $urandom_range(max_wait, 0);
            d[j] = $urandom;
            f[j] = 1'($urandom);
        end
    endtask

    // Drives one sweep and checks every cycle; -1 disables the optional events.
    task automatic do_sweep(input int ovr_at, input bit clr_same, input int clr_at, input int abort_at);
        int fs[N];
        int done_c, k, exp_idx;
        bit fetch, rd, wr, pend_set, pend_clr;
        fs[0] = 1;
        for (int j = 1; j < N; j++) fs[j] = fs[j-1] + w[j-1] + 3;
        done_c = fs[N-1] + w[N-1] + 3;
        pend_set = 0; pend_clr = 0;
        @(negedge clk);
        tick = 1; enable = 1; clear_overrun = 0;
        cur_valid = 1'($urandom); cur_data = $urandom; core_fired = 1'($urandom);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (pend_set) exp_ovr = 1; else if (pend_clr) exp_ovr = 0;
            pend_set = 0; pend_clr = 0;
            if (c == abort_at) begin
                reset = 1; tick = 0; clear_overrun = 0; cur_valid = 0; core_fired = 0;
                #1;
                exp_pop = '0; exp_cnt = '0; exp_fp = 1; exp_ovr = 0;
                n_cmp++;
                if (outs() !== rst_exp) begin
                    n_bad++; $display("FAIL abort_reset c=%0d got=%h want=%h", c, outs(), rst_exp);
                end
                @(negedge clk);
                reset = 0;
                return;
            end
            k = -1;
            for (int j = 0; j < N; j++) if (c >= fs[j] && c <= fs[j] + w[j] + 2) k = j;
            fetch = (k >= 0) && (c <= fs[k] + w[k]);
            rd    = (k >= 0) && (c == fs[k] + w[k] + 1);
            wr    = (k >= 0) && (c == fs[k] + w[k] + 2);
            if (c == done_c) begin
                for (int j = 0; j < N; j++) exp_pop[j] = f[j];
                exp_cnt++; exp_fp = 0;
            end
            exp_idx = (k >= 0) ? k : N - 1;
            n_cmp += 9;
            if (busy !== (c <= done_c)) begin n_bad++; $display("FAIL busy c=%0d got=%b want=%b", c, busy, c <= done_c); end
            if (cur_req !== fetch) begin n_bad++; $display("FAIL cur_req c=%0d got=%b want=%b", c, cur_req, fetch); end
            if (core_we !== wr) begin n_bad++; $display("FAIL core_we c=%0d got=%b want=%b", c, core_we, wr); end
            if (sweep_done !== (c == done_c)) begin n_bad++; $display("FAIL sweep_done c=%0d got=%b want=%b", c, sweep_done, c == done_c); end
            if (core_addr !== AW'(exp_idx)) begin n_bad++; $display("FAIL core_addr c=%0d got=%0d want=%0d", c, core_addr, exp_idx); end
            if (population !== exp_pop) begin n_bad++; $display("FAIL population c=%0d got=%b want=%b", c, population, exp_pop); end
            if (sweep_count !== exp_cnt) begin n_bad++; $display("FAIL sweep_count c=%0d got=%0d want=%0d", c, sweep_count, exp_cnt); end
            if (core_first_pass !== exp_fp) begin n_bad++; $display("FAIL first_pass c=%0d got=%b want=%b", c, core_first_pass, exp_fp); end
            if (overrun !== exp_ovr) begin n_bad++; $display("FAIL overrun c=%0d got=%b want=%b", c, overrun, exp_ovr); end
            if (fetch) begin
                n_cmp++;
                if (cur_addr !== AW'(k)) begin n_bad++; $display("FAIL cur_addr c=%0d got=%0d want=%0d", c, cur_addr, k); end
                if (k > 0) begin
                    n_cmp++;
                    if (core_I !== d[k-1]) begin n_bad++; $display("FAIL core_I_hold c=%0d got=%h want=%h", c, core_I, d[k-1]); end
                end
            end
            if (rd || wr) begin
                n_cmp++;
                if (core_I !== d[k]) begin n_bad++; $display("FAIL core_I c=%0d got=%h want=%h", c, core_I, d[k]); end
            end
            // next-cycle stimulus; fields outside their window carry noise the DUT must ignore
            tick = 0; clear_overrun = 0;
            enable = 1'($urandom); cur_valid = 1'($urandom);
            cur_data = $urandom; core_fired = 1'($urandom);
            if (fetch) begin cur_data = d[k]; cur_valid = (c == fs[k] + w[k]); end
            if (wr) core_fired = f[k];
            if (c == ovr_at) begin tick = 1; clear_overrun = clr_same; pend_set = 1; end
            else if (c == clr_at) begin clear_overrun = 1; pend_clr = 1; end
        end
    endtask

    task automatic test_reset();
        reset = 1; tick = 0; enable = 0; clear_overrun = 0;
        cur_valid = 0; cur_data = '0; core_fired = 0;
        exp_pop = '0; exp_cnt = '0; exp_fp = 1; exp_ovr = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== rst_exp) begin n_bad++; $display("FAIL reset_state i=%0d got=%h want=%h", i, outs(), rst_exp); end
        end
    endtask

    task automatic test_basic();
        randomize_sweep(0);
        do_sweep(-1, 0, -1, -1);
    endtask

    task automatic test_random_sweeps();
        for (int i = 0; i < 6; i++) begin
            randomize_sweep(3);
            do_sweep(-1, 0, -1, -1);
        end
    endtask

    task automatic test_stall();
        randomize_sweep(0);
        w[2] = 4;
        do_sweep(-1, 0, -1, -1);
    endtask

    task automatic test_population();
        randomize_sweep(1);
        for (int j = 0; j < N; j++) f[j] = (j == 1);
        do_sweep(-1, 0, -1, -1);
    endtask

    task automatic test_enable_gate();
        @(negedge clk);
        tick = 1; enable = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick = 0;
            n_cmp += 2;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL gated_busy i=%0d got=%b want=0", i, busy); end
            if (overrun !== exp_ovr) begin n_bad++; $display("FAIL gated_overrun i=%0d got=%b want=%b", i, overrun, exp_ovr); end
        end
    endtask

    task automatic test_overrun();
        randomize_sweep(0);
        do_sweep(5, 0, -1, -1);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
        end
        clear_overrun = 1;
        @(negedge clk);
        clear_overrun = 0; exp_ovr = 0;
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got=%b want=0", overrun); end
        randomize_sweep(2);
        do_sweep(4, 1, -1, -1);
        randomize_sweep(2);
        do_sweep(-1, 0, 6, -1);
        randomize_sweep(0);
        do_sweep(3 * N + 1, 0, -1, -1);
        clear_overrun = 1;
        @(negedge clk);
        clear_overrun = 0; exp_ovr = 0;
    endtask

    task automatic test_reset_mid_sweep();
        randomize_sweep(1);
        do_sweep(-1, 0, -1, -1);
        randomize_sweep(1);
        do_sweep(-1, 0, -1, 7);
        randomize_sweep(1);
        do_sweep(-1, 0, -1, -1);
    endtask

    initial begin
        rst_exp = {6'b000001, {(RW-6){1'b0}}};
        test_reset();
        test_basic();
        test_random_sweeps();
        test_stall();
        test_population();
        test_enable_gate();
        test_overrun();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/izh_population_sequencer.md
# izh_population_sequencer

Sweep controller for the time-multiplexed Izhikevich population core. On each integration tick it walks every neuron index once, fetches that neuron's input current from an upstream current source over a valid/ready-style handshake, and drives the core's address, current and write-enable strobes in a fixed read/compute/write rhythm. It owns the first-pass (initial-condition) flag, gathers the per-neuron fire bits into a population vector, and flags ticks that arrive while a sweep is still running.

## Interface
- N_NEURONS, 128, number of neurons swept per tick (≥2)
- ADDR_W, 7, index width; must satisfy 2^ADDR_W ≥ N_NEURONS

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle sweep request (integration step)
- enable  in  1  gates acceptance of tick; does not abort a running sweep
- clear_overrun  in  1  clears the overrun flag
- cur_req  out  1  current request to upstream source
- cur_addr  out  ADDR_W  neuron index being requested
- cur_valid  in  1  cur_data valid; completes the handshake when cur_req=1
- cur_data  in  32  signed input current for cur_addr, Q10 scaled
- core_addr  out  ADDR_W  neuron index presented to the core RAMs
- core_I  out  32  signed latched current for core_addr
- core_we  out  1  core RAM write strobe
- core_first_pass  out  1  core selects initial u/v instead of RAM contents
- core_fired  in  1  core's combinational fire decision for core_addr
- busy  out  1  high in every state except IDLE
- sweep_done  out  1  one-cycle pulse at sweep end
- population  out  N_NEURONS  fire bits of last completed sweep; bit k = neuron k
- sweep_count  out  32  completed sweeps, wraps at 2^32
- overrun  out  1  sticky; a tick was dropped

## Operation
- FSM states: IDLE, FETCH, READ, WRITE, DONE. Index register idx.
- IDLE: on tick=1 and enable=1, clear idx to 0 and go to FETCH. Otherwise stay in IDLE.
- FETCH: cur_req=1 and cur_addr=idx.
  - If cur_valid=1: core_I<=cur_data, then READ.
  - Else stay in FETCH; the wait is unbounded.
- READ: core_addr=idx and core_we=0 for one cycle, which covers RAM read latency. Then WRITE.
- WRITE: core_we=1 for exactly one cycle. Shadow[idx]<=core_fired.
  - If idx=N_NEURONS-1: population<={core_fired, shadow[N-2:0]}, sweep_count increments, core_first_pass<=0, then DONE.
  - Else idx<=idx+1, then FETCH.
- DONE: sweep_done=1 for one cycle, then IDLE.
- core_addr equals idx in all states. core_I holds its value between fetches.
- Tick handling:
  - A tick while busy=1 is dropped and sets overrun.
  - A tick with enable=0 in IDLE is ignored and does not set overrun.
  - If clear_overrun and an overrun-setting tick arrive in the same cycle, set wins.
- enable falling mid-sweep has no effect; the sweep completes.
- cur_valid outside FETCH is ignored.

## Timing
- Reset values:
  - State IDLE, idx=0.
  - cur_req, core_we, busy, sweep_done, overrun all 0.
  - core_I, cur_addr, core_addr, population, sweep_count all 0.
  - core_first_pass=1.
- Reset mid-sweep aborts immediately and returns every output to its reset value, including first_pass=1. Partial shadow bits are discarded.
- With cur_valid tied high and tick sampled at edge t:
  - FETCH(k) occurs at cycle t+1+3k, READ(k) at t+2+3k, WRITE(k) at t+3+3k.
  - DONE and the sweep_done pulse occur at cycle t+3N+1.
  - A sweep takes 3N+1 cycles. The earliest accepted next tick is at cycle t+3N+2, i.e. in IDLE.
- Each FETCH wait cycle adds one cycle of latency.
- population, sweep_count and core_first_pass are already updated when sweep_done is high.
- overrun rises on the cycle after the dropped tick.

## Test plan
- Reset, then hold 5 cycles with no tick → outputs at reset values, busy=0.
- N=4, cur_valid=1, tick at cycle 0:
  - core_we high at cycles 3,6,9,12.
  - core_I equals cur_data for the matching index.
  - sweep_done at cycle 13.
  - sweep_count=1, core_first_pass=0 from cycle 13.
- cur_valid withheld 4 cycles on index 2 → cur_req stays high with cur_addr=2, and sweep_done is delayed by exactly 4 cycles.
- core_fired=1 only while idx=1 and only during WRITE → population=4'b0010 at sweep_done, not earlier.
- Tick at cycle 5 of a running sweep → overrun=1 at cycle 6, that tick is dropped, and overrun stays 1 until clear_overrun.
- Reset asserted at cycle 7 of the second sweep → core_first_pass=1, population=0, state IDLE. The next tick restarts from index 0.
